// File: rtl/abs_pkg.sv
// Shared definitions for the bit-serial absolute-value / negate unit.
package abs_pkg;

  // Controller states: wait for operand, stream bits through the cell, hold result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation select, sampled together with the operand.
  localparam logic OP_ABS = 1'b0;
  localparam logic OP_NEG = 1'b1;

  // Most-negative two's-complement value of a given width (widths up to 64).
  function automatic logic [63:0] most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/abs_bit_cell.sv
// Serial two's-complement cell: copies bits up to and including the first 1,
// then inverts every later bit when negation is requested.
module abs_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic neg,
  input  logic clr,
  input  logic en,
  output logic obit
);

  logic seen_one;

  // Remember whether a 1 has already passed through this operand.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | a;
    end
  end

  assign obit = a ^ (neg & seen_one);

endmodule

// File: rtl/abs_serial.sv
// Bit-serial |x| / -x unit, LSB first, one complement cell reused for WIDTH cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on the state (high in IDLE), never on out_ready.
// out_valid stays high with dout/overflow stable until out_ready is seen, and
// in_valid is ignored whenever the unit is not idle.
import abs_pkg::*;

module abs_serial #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam int                CW          = $clog2(WIDTH);
  localparam logic [63:0]       MOST_NEG_64 = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]  MOST_NEG    = MOST_NEG_64[WIDTH-1:0];
  localparam logic [WIDTH-1:0]  MAX_POS     = ~MOST_NEG;
  localparam logic [CW-1:0]     LAST        = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    count;
  logic             neg;
  logic             ovf;
  logic             din_neg;
  logic             accept;
  logic             shift_en;
  logic             cell_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign shift_en  = (state == SHIFT);
  assign din_neg   = (op == OP_NEG) | din[WIDTH-1];
  assign res_next  = {cell_bit, res[WIDTH-1:1]};

  abs_bit_cell u_cell (
    .clk  (clk),
    .rst  (rst),
    .a    (opnd[0]),
    .neg  (neg),
    .clr  (accept),
    .en   (shift_en),
    .obit (cell_bit)
  );

  // Controller, operand/result shift registers and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opnd     <= '0;
      res      <= '0;
      count    <= '0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opnd  <= din;
            res   <= '0;
            neg   <= din_neg;
            // Negating the most-negative value cannot be represented.
            ovf   <= (din == MOST_NEG) & din_neg;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          opnd  <= opnd >> 1;
          res   <= res_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state    <= DONE;
            dout     <= (SAT && ovf) ? MAX_POS : res_next;
            overflow <= ovf;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
